sram_ctrl: RTL
==============

# sram_ctrl

Multi-cycle controller between the core's memory read/write request port and the external 16-bit asynchronous SRAM pins (5-bit active-low control bundle, 16-bit address, bidirectional 16-bit data). It accepts one request at a time with a valid/ready handshake. It sequences setup, strobe and hold phases with fixed cycle counts, owns the tri-state enable of the data bus, and returns registered read data with a one-cycle response strobe. It replaces direct OR-wiring of the request arguments onto the pins.

## Interface
Parameters:
- ACCESS_CYCLES, 2: cycles the WE_n/OE_n strobe is held low. Legal range 1..15; a 4-bit counter holds it.

Ports:
- CLK  in  1: single clock; every flop is on its rising edge.
- RESET  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: controller can accept a request. A request is accepted on an edge where req_valid && req_ready.
- req_write  in  1: 1 = write, 0 = read.
- req_addr  in  16: word address.
- req_wdata  in  16: write data.
- req_be  in  2: byte enables for writes; [0] = low byte, [1] = high byte.
- rsp_valid  out  1: one-cycle pulse; rsp_rdata is valid. Reads only.
- rsp_rdata  out  16: read data, held until the next read response.
- mem_ctl_n  out  5: {UB_n, LB_n, WE_n, OE_n, CE_n}, bits [4:0], all active-low.
- mem_addr  out  16: SRAM address.
- mem_dq  inout  16: SRAM data bus.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - mem_ctl_n = 5'b11111; mem_dq is high-Z.
  - req_ready = 1 when RESET is low.
  - On accept: latch write, addr, wdata and be, then go to SETUP.
- SETUP, 1 cycle:
  - mem_addr is driven; CE_n = 0; OE_n = WE_n = 1.
  - Writes: mem_dq drives wdata; LB_n/UB_n = ~be.
  - Reads: LB_n = UB_n = 0, regardless of req_be.
- STROBE, ACCESS_CYCLES cycles:
  - Writes drive WE_n = 0; reads drive OE_n = 0.
  - Counter loads ACCESS_CYCLES-1 on entry and decrements. Exit to HOLD when it reaches 0.
  - Reads: mem_dq is sampled into rsp_rdata on the edge that leaves STROBE.
- HOLD, 1 cycle:
  - WE_n = OE_n = 1; CE_n, address, byte lanes and write data held.
  - Reads pulse rsp_valid = 1 in this cycle.
  - Next state is IDLE, or SETUP per Configuration.
- mem_dq output enable is asserted only for writes, from SETUP through HOLD inclusive. It is never asserted while OE_n = 0.
- Requests arriving while req_ready = 0 are not accepted. The requester must hold req_valid and its payload stable until acceptance.
- Reset, including mid-operation: the next edge with RESET high forces IDLE, mem_ctl_n = 5'b11111, mem_addr = 0, mem_dq high-Z, rsp_valid = 0, rsp_rdata = 0, counter = 0, req_ready = 0. An aborted access produces no response.

## Timing
- Accept edge E0:
  - SETUP in cycle 1.
  - STROBE in cycles 2..1+ACCESS_CYCLES.
  - HOLD in cycle 2+ACCESS_CYCLES; rsp_valid is high in this cycle.
- Read latency, accept edge to rsp_valid: 2+ACCESS_CYCLES cycles (4 at the default).
- Request period: ACCESS_CYCLES+3 cycles without the macro; ACCESS_CYCLES+2 with it.
- All pin outputs are registered.
- req_ready is combinational from state and RESET only, never from req_valid.

## Configuration
- SRAM_CTRL_BACK2BACK_EN defined:
  - req_ready is also 1 in HOLD.
  - A request accepted in HOLD goes directly to SETUP and skips IDLE.
  - Read-after-write is safe: mem_dq output enable drops in SETUP, and OE_n stays 1 there.
- Undefined: req_ready is 1 in IDLE only, and HOLD always returns to IDLE.

## Structure
- Package sram_ctrl_pkg holds:
  - the state enum;
  - bit-index constants CTL_CE, CTL_OE, CTL_WE, CTL_LB, CTL_UB;
  - CTL_IDLE = 5'b11111;
  - the request struct {write, addr, wdata, be}.
- Sub-module sram_dq_iobuf contains the tri-state driver on mem_dq and the input capture register. Its ports are oe, dout, din, capture and q. The FSM stays in sram_ctrl.

## Test plan
- Write A=0x1234, D=0xBEEF, be=2'b11, ACCESS_CYCLES=2:
  - WE_n low exactly on cycles 2–3 after accept.
  - mem_dq = 0xBEEF from cycle 1 to cycle 4.
  - No rsp_valid.
- Read A=0x1234 with the model returning 0xBEEF:
  - OE_n low on cycles 2–3.
  - mem_dq is never driven.
  - rsp_valid on cycle 4 with rsp_rdata = 0xBEEF.
- Write with be=2'b01, then read: LB_n = 0 and UB_n = 1 during the write; the model high byte is unchanged.
- req_valid held continuously with alternating write/read:
  - Accept spacing is 5 cycles (4 with SRAM_CTRL_BACK2BACK_EN).
  - The bench model flags no bus contention.
- RESET asserted in the second STROBE cycle of a read:
  - Next cycle: mem_ctl_n = 5'b11111, rsp_valid never pulses, req_ready = 0.
  - req_ready = 1 the cycle after RESET falls.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=15: strobe width equals the parameter exactly, and read latency is 3 and 17 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller:
// FSM states, control-bundle bit positions and the latched request record.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    // Bit positions inside the active-low bundle {UB_n, LB_n, WE_n, OE_n, CE_n}
    localparam int CTL_CE = 0;
    localparam int CTL_OE = 1;
    localparam int CTL_WE = 2;
    localparam int CTL_LB = 3;
    localparam int CTL_UB = 4;

    localparam logic [4:0] CTL_IDLE = 5'b11111;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } req_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side request/response bundle of the SRAM controller.
// The core drives through master, the controller answers through slave.
interface sram_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_dq_iobuf.sv
// Tri-state driver for the SRAM data pins plus the read-data capture register.
// din is the bidirectional pin itself: driven from dout while oe is set, sampled into q on capture.
module sram_dq_iobuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        oe,
    input  logic [15:0] dout,
    inout  wire  [15:0] din,
    input  logic        capture,
    output logic [15:0] q
);

    assign din = oe ? dout : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (capture) begin
            q <= din;
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle controller driving a 16-bit asynchronous SRAM with setup/strobe/hold phases.
// Define SRAM_CTRL_BACK2BACK_EN to accept the next request during HOLD and skip IDLE.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    sram_ctrl_if.slave  bus,
    output logic [4:0]  mem_ctl_n,
    output logic [15:0] mem_addr,
    inout  wire  [15:0] mem_dq
);

    state_t      state_q, state_d;
    req_t        req_q, req_d, req_in;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        capture;
    logic        rsp_valid_q;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] addr_d;
    logic [4:0]  ctl_d;
    logic [15:0] rdata;

    assign req_in = {bus.req_write, bus.req_addr, bus.req_wdata, bus.req_be};

    always_comb begin
        bus.req_ready = 1'b0;
        if (!RESET) begin
`ifdef SRAM_CTRL_BACK2BACK_EN
            bus.req_ready = (state_q == IDLE) || (state_q == HOLD);
`else
            bus.req_ready = (state_q == IDLE);
`endif
        end
    end

    assign accept = bus.req_valid && bus.req_ready;

    // Pins are registered, so their next values are decoded from the next state and request.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = req_in;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'(ACCESS_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    capture = !req_q.write;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
`ifdef SRAM_CTRL_BACK2BACK_EN
                if (accept) begin
                    req_d   = req_in;
                    state_d = SETUP;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        ctl_d   = CTL_IDLE;
        addr_d  = mem_addr;
        dq_oe_d = 1'b0;
        dout_d  = req_d.wdata;
        if (state_d != IDLE) begin
            addr_d         = req_d.addr;
            ctl_d[CTL_CE]  = 1'b0;
            dq_oe_d        = req_d.write;
            ctl_d[CTL_LB]  = req_d.write ? ~req_d.be[0] : 1'b0;
            ctl_d[CTL_UB]  = req_d.write ? ~req_d.be[1] : 1'b0;
            if (state_d == STROBE) begin
                if (req_d.write) begin
                    ctl_d[CTL_WE] = 1'b0;
                end else begin
                    ctl_d[CTL_OE] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            mem_ctl_n   <= CTL_IDLE;
            mem_addr    <= '0;
            dq_oe_q     <= 1'b0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            mem_ctl_n   <= ctl_d;
            mem_addr    <= addr_d;
            dq_oe_q     <= dq_oe_d;
            dout_q      <= dout_d;
            rsp_valid_q <= capture;
        end
    end

    sram_dq_iobuf u_iobuf (
        .clk     (CLK),
        .rst     (RESET),
        .oe      (dq_oe_q),
        .dout    (dout_q),
        .din     (mem_dq),
        .capture (capture),
        .q       (rdata)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata;

endmodule
